pipelined_csel_adder: RTL and testbench
=======================================

// Module: pipelined_csel_adder
// PURPOSE
//  Parametrised, pipelined carry-select add/subtract unit. Successor to the fixed 32-bit
//  combinational carry-select adder. Splits the operand into STAGES slices. Each slice is
//  built from BLOCK-bit carry-select blocks and computes one slice per clock. Sits between
//  a producer and a consumer on a valid/ready stream.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits; WIDTH % (STAGES*BLOCK) == 0 (elaboration error otherwise)
//  BLOCK   4   bits per carry-select block (dual ripple adders, cin=0 and cin=1, muxed by carry)
//  STAGES  4   pipeline slices; latency = STAGES cycles; WIDTH/STAGES bits resolved per stage
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid this cycle
//  in_ready   out  1      unit accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (ignored when sub=1)
//  sub        in   1      0: a+b+cin; 1: a-b (b inverted, carry in forced 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  s          out  WIDTH  sum/difference
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits, out_valid, s, cout, ovf = 0.
//    Pipeline contents are discarded. in_ready = 1 immediately after reset is released.
//  - Transfer rule: a transfer occurs on a clock edge where valid && ready.
//    in_ready = !(out_valid && !out_ready). This is a global stall and needs no skid buffer.
//  - Stall: when out_valid=1 and out_ready=0, every stage register holds, including
//    unprocessed upper operand bits and partial sums. s, cout, ovf stay stable. in_ready=0.
//  - Stage k (0..STAGES-1):
//    - adds bits [k*W/S +: W/S] using the carry registered by stage k-1 (stage 0 uses cin or sub).
//    - forwards the upper operand bits and the lower partial sum.
//    - Inside a stage the carry ripples across blocks only through the select muxes.
//  - Latency: operands accepted on edge N give out_valid=1 after edge N+STAGES, provided no stall.
//    Throughput is 1 result per cycle; bubbles propagate as valid=0.
//  - The valid bit travels with its data. Stages holding valid=0 still shift and do not corrupt results.
//  - Width: internal add is WIDTH+1 bits. cout is bit WIDTH. ovf = c[WIDTH-1] ^ c[WIDTH].
//  - Wrap-around: s is the result modulo 2^WIDTH (example: all-ones + 1 gives s=0, cout=1).
//  - Simultaneous events:
//    - Input accept and output drain in the same cycle are both legal and lose no data.
//    - out_ready=0 while in_valid=1 blocks the input. The producer holds a, b, cin, sub.
//  - Reset mid-operation: in-flight results are lost. No out_valid pulse occurs after rst_n deasserts
//    until new operands pass through all STAGES.
// CONFIGURATION
//  PCSA_SATURATE_EN defined:
//   - Adds input sat (1 bit, signed saturation request).
//   - sat travels with the data. When sat=1 and ovf=1, s is clamped:
//     32'h7FFF_FFFF for positive overflow, 32'h8000_0000 for negative overflow (generalised to WIDTH).
//     ovf is still reported.
//   - Clamping happens in the last stage and does not change latency.
//  PCSA_SATURATE_EN undefined: the sat port does not exist and s always wraps.
// TESTING  (defaults WIDTH=32, BLOCK=4, STAGES=4)
//  1 Reset: rst_n=0 mid-stream with 3 ops in flight -> out_valid=0, s=0 at once; no stale output after release.
//  2 Add: a=2, b=17, cin=0 -> s=19, cout=0, after exactly 4 cycles.
//    Then back-to-back a=8, b=24 -> 32 and a=4, b=48 -> 52 on consecutive cycles.
//  3 Carry chain: a=32'hFFFF_FFFF, b=1 -> s=0, cout=1, ovf=0.
//    a=32'h7FFF_FFFF, b=1 -> s=32'h8000_0000, ovf=1.
//  4 Subtract: a=5, b=7, sub=1 -> s=32'hFFFF_FFFE, cout=0.
//    a=7, b=5, sub=1 -> s=2, cout=1.
//  5 Backpressure: stream 6 ops, hold out_ready=0 for 5 cycles after the first result ->
//    in_ready=0 and s stable throughout; all 6 results arrive in order with none lost or duplicated.
//  6 Saturation (PCSA_SATURATE_EN): sat=1, a=32'h7FFF_FFFF, b=1 -> s=32'h7FFF_FFFF, ovf=1.
//    sat=1, a=32'h8000_0000, b=32'hFFFF_FFFF -> s=32'h8000_0000.

Source files
------------

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select add/subtract unit: WIDTH/STAGES bits are resolved per stage, one stage per clock.
// Optional signed saturation is enabled by defining PCSA_SATURATE_EN (adds the sat input).
module pipelined_csel_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PCSA_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = WIDTH / STAGES;
  localparam int NB = SW / BLOCK;
  localparam int L  = STAGES - 1;

  if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a multiple of STAGES*BLOCK");
  end

  logic sat_in;
`ifdef PCSA_SATURATE_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  logic             out_valid_q, cout_q, ovf_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_d, ovf_d, c_msb;
  logic [WIDTH-1:0] s_d;

  // Handshake: a transfer happens on a rising edge where valid && ready. A full output
  // that the consumer refuses freezes every stage, so no skid buffer is needed.
  assign in_ready = !(out_valid_q && !out_ready);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Bank k holds only the operand bits not yet consumed; the slice for stage k sits at the bottom.
    localparam int RW = WIDTH - k * SW;
    logic             valid_q, carry_q, sat_q, valid_d, carry_d, sat_d;
    logic [RW-1:0]    a_q, b_q, a_d, b_d;
    logic [WIDTH-1:0] sum_q, sum_d, sum_o;
    logic [SW-1:0]    slice;
    logic             c_out;

    if (k == 0) begin : g_feed
      always_comb begin
        valid_d = in_valid;
        a_d     = a;
        b_d     = sub ? ~b : b;
        carry_d = sub | cin;
        sat_d   = sat_in;
        sum_d   = '0;
      end
    end else begin : g_feed
      always_comb begin
        valid_d = g_stage[k-1].valid_q;
        a_d     = g_stage[k-1].a_q[RW+SW-1:SW];
        b_d     = g_stage[k-1].b_q[RW+SW-1:SW];
        carry_d = g_stage[k-1].c_out;
        sat_d   = g_stage[k-1].sat_q;
        sum_d   = g_stage[k-1].sum_o;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sat_q   <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        sum_q   <= '0;
      end else if (in_ready) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sat_q   <= sat_d;
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
      end
    end

    // Both block results are formed without the incoming carry; the carry only drives the muxes.
    always_comb begin : slice_add
      logic             c;
      logic [BLOCK:0]   r0, r1, rs;
      c     = carry_q;
      slice = '0;
      r0    = '0;
      r1    = '0;
      rs    = '0;
      for (int j = 0; j < NB; j++) begin
        r0 = {1'b0, a_q[j*BLOCK +: BLOCK]} + {1'b0, b_q[j*BLOCK +: BLOCK]};
        r1 = {1'b0, a_q[j*BLOCK +: BLOCK]} + {1'b0, b_q[j*BLOCK +: BLOCK]} + {{BLOCK{1'b0}}, 1'b1};
        rs = c ? r1 : r0;
        slice[j*BLOCK +: BLOCK] = rs[BLOCK-1:0];
        c = rs[BLOCK];
      end
      c_out = c;
    end

    assign sum_o = sum_q | (WIDTH'(slice) << (k * SW));
  end

  // Carry into the MSB is recovered from the MSB operand and sum bits of the last slice.
  always_comb begin
    s_d    = g_stage[L].sum_o;
    cout_d = g_stage[L].c_out;
    c_msb  = g_stage[L].a_q[SW-1] ^ g_stage[L].b_q[SW-1] ^ s_d[WIDTH-1];
    ovf_d  = c_msb ^ cout_d;
    if (g_stage[L].sat_q && ovf_d) begin
      s_d = s_d[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= g_stage[L].valid_q;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed bench for pipelined_csel_adder (WIDTH=32, BLOCK=4, STAGES=4); results are {cout, ovf, s}.
module tb_pipelined_csel_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub, sat_r;
  logic         out_valid, out_ready;
  logic [W-1:0] s;
  logic         cout, ovf;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(W), .BLOCK(4), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef PCSA_SATURATE_EN
    .sat(sat_r),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  function automatic logic [W+1:0] mk(input logic c, input logic o, input logic [W-1:0] v);
    return {c, o, v};
  endfunction

  task automatic chk(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted result is compared in order against the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out observed=%h expected=none", {cout, ovf, s});
        end
      end else begin
        chk("result", {cout, ovf, s}, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge with in_valid still high.
  task automatic send(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                      input logic op_sub, input logic op_sat, input logic [W+1:0] texp);
    int n;
    a = op_a; b = op_b; cin = op_cin; sub = op_sub; sat_r = op_sat; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", in_ready, 1);
    exp_q.push_back(texp);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic seen;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat_r = 1'b0;
    out_ready = 1'b1; rst_n = 1'b0;

    // Reset values and release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {cout, ovf, s}, 0);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // Latency of exactly four cycles
    send(32'd2, 32'd17, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd19));
    in_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 20);
    chk("latency", cyc, 4);
    wait_drain();

    // Back-to-back
    send(32'd8, 32'd24, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd32));
    send(32'd4, 32'd48, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd52));
    wait_drain();

    // Carry chain, overflow, cin and subtract
    send(32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h0));
    send(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 32'h8000_0000));
    send(32'h0000_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h0001_0000));
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 32'h0));
    send(32'd10,        32'd20,        1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd31));
    send(32'd5,         32'd7,         1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 32'hFFFF_FFFE));
    send(32'd7,         32'd5,         1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 32'd2));
    send(32'h0,         32'h0,         1'b0, 1'b1, 1'b0, mk(1'b1, 1'b0, 32'h0));
    send(32'h8000_0000, 32'h1,         1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 32'h7FFF_FFFF));
    wait_drain();

    // Reset with three operations in flight and the first result stalled at the output
    send(32'd100, 32'd200, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd300));
    send(32'd101, 32'd200, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd301));
    send(32'd102, 32'd200, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd302));
    out_ready = 1'b0;
    idle(2);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", {cout, ovf, s}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_out", seen, 0);
    @(posedge clk); #1;

    // Backpressure: stall five cycles after the first of six results
    fork
      begin
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h0000_0003));
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h0000_0030));
        send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h0000_0300));
        idle(3);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h0000_0000));
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h2345_6789));
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h1010_1010));
        in_valid = 1'b0;
      end
      begin
        cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 50) begin
          @(negedge clk);
          cyc++;
        end
        chk("bp_first_out", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_held", {cout, ovf, s}, mk(1'b0, 1'b0, 32'h0000_0030));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

`ifdef PCSA_SATURATE_EN
    // Saturation clamps only when overflow occurs
    send(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 32'h7FFF_FFFF));
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, mk(1'b1, 1'b1, 32'h8000_0000));
    send(32'h8000_0000, 32'h1,         1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 32'h8000_0000));
    send(32'd5,         32'd7,         1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 32'hFFFF_FFFE));
    wait_drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
